// File: rtl/coin_accumulator.sv
// Coin key front end: per-key 2-flop sync, debounce and rising-edge pulse, plus the
// saturating credit register driven by the seller FSM's clear/freeze controls.
module coin_accumulator #(
    parameter int DEBOUNCE  = 4,
    parameter int INC1      = 2,
    parameter int INC10     = 20,
    parameter int MONEY_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rmb1_key,
    input  logic       rmb10_key,
    input  logic       accurst,
    input  logic       acculock,
    output logic       rmb1,
    output logic       rmb10,
    output logic [7:0] money,
    output logic       sat
);

    localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

    // Index 0 carries the 1 RMB key, index 1 the 10 RMB key.
    logic [1:0]         sync0_q, sync1_q;
    logic [1:0]         filt_q, filt_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         rise;
    logic [1:0]         pulse_q, pulse_d;
    logic [7:0]         money_q, money_d;
    logic               sat_q, sat_d;
    logic [9:0]         sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q <= '0;
            sync1_q <= '0;
            filt_q  <= '0;
            cnt_q   <= '0;
            pulse_q <= '0;
            money_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            sync0_q <= {rmb10_key, rmb1_key};
            sync1_q <= sync0_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            money_q <= money_d;
            sat_q   <= sat_d;
        end
    end

    // Accepting a new level and flagging its rising edge happen on the same edge.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        rise   = '0;
        for (int k = 0; k < 2; k++) begin
            if (sync1_q[k] != filt_q[k]) begin
                if (cnt_q[k] == CW'(DEBOUNCE - 1)) begin
                    filt_d[k] = sync1_q[k];
                    cnt_d[k]  = '0;
                    rise[k]   = sync1_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end else begin
                cnt_d[k] = '0;
            end
        end
    end

    always_comb begin
        money_d = money_q;
        sat_d   = sat_q;
        pulse_d = '0;
        sum     = {2'b00, money_q}
                + (rise[0] ? 10'(INC1)  : 10'd0)
                + (rise[1] ? 10'(INC10) : 10'd0);
        if (accurst) begin
            money_d = '0;
            sat_d   = 1'b0;
        end else if (!acculock) begin
            pulse_d = rise;
            if (sum > 10'(MONEY_MAX)) begin
                money_d = 8'(MONEY_MAX);
                sat_d   = 1'b1;
            end else begin
                money_d = sum[7:0];
            end
        end
    end

    assign rmb1  = pulse_q[0];
    assign rmb10 = pulse_q[1];
    assign money = money_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Bench for coin_accumulator: scenario tasks plus a pulse scoreboard that pops the
// expected {rmb10, rmb1, sat, money} whenever the DUT emits a coin pulse.
module tb_coin_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rmb1_key = 1'b0;
  logic       rmb10_key = 1'b0;
  logic       accurst = 1'b0;
  logic       acculock = 1'b0;
  logic       rmb1, rmb10, sat;
  logic [7:0] money;

  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          m_money = 0;
  bit          m_sat = 1'b0;

  coin_accumulator #(
    .DEBOUNCE(4), .INC1(2), .INC10(20), .MONEY_MAX(255)
  ) dut (
    .clk(clk), .rst(rst), .rmb1_key(rmb1_key), .rmb10_key(rmb10_key),
    .accurst(accurst), .acculock(acculock),
    .rmb1(rmb1), .rmb10(rmb10), .money(money), .sat(sat)
  );

  always #5 clk = ~clk;

  // Scoreboard: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [10:0] e;
    logic [10:0] got;
    if (!rst && (rmb1 || rmb10)) begin
      got = {rmb10, rmb1, sat, money};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse got=%h (no pulse expected)", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL pulse_scoreboard got=%h expected=%h", got, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input bit k1, input bit k10);
    int s;
    s = m_money + (k1 ? 2 : 0) + (k10 ? 20 : 0);
    if (s > 255) begin
      m_money = 255;
      m_sat = 1'b1;
    end else begin
      m_money = s;
    end
    exp_q.push_back({k10, k1, m_sat, 8'(m_money)});
  endtask

  task automatic clear_credit();
    step();
    accurst = 1'b1;
    step();
    accurst = 1'b0;
    m_money = 0;
    m_sat = 1'b0;
  endtask

  task automatic coin(input bit k1, input bit k10);
    model_push(k1, k10);
    step();
    rmb1_key = k1;
    rmb10_key = k10;
    repeat (8) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL coin_pulse_timeout pending=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
    rmb1_key = 1'b0;
    rmb10_key = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({rmb10, rmb1, sat, money} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h expected=000", {rmb10, rmb1, sat, money});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int first = 0;
    int pulses = 0;
    logic [7:0] m_at = 8'd0;
    model_push(1'b1, 1'b0);
    step();
    rmb1_key = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (rmb1) begin
        pulses++;
        if (first == 0) begin
          first = e;
          m_at = money;
        end
      end
    end
    rmb1_key = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step();
      if (rmb1) pulses++;
    end
    n_checks++;
    if (first != 6) begin
      n_fail++;
      $display("FAIL single_latency got=%0d expected=6", first);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL single_pulse_count got=%0d expected=1", pulses);
    end
    n_checks++;
    if (m_at !== 8'd2) begin
      n_fail++;
      $display("FAIL single_money_at_pulse got=%0d expected=2", m_at);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    int first = 0;
    int pulses = 0;
    pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
    clear_credit();
    model_push(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      rmb10_key = pat[i];
      step();
      if (rmb10) pulses++;
    end
    rmb10_key = 1'b1;
    for (int e = 6; e <= 20; e++) begin
      step();
      if (rmb10) begin
        pulses++;
        if (first == 0) first = e;
      end
    end
    rmb10_key = 1'b0;
    repeat (10) step();
    n_checks++;
    if (first != 11 || pulses != 1) begin
      n_fail++;
      $display("FAIL bounce_pulse got edge=%0d count=%0d expected edge=11 count=1", first, pulses);
    end
    n_checks++;
    if (money !== 8'd20) begin
      n_fail++;
      $display("FAIL bounce_money got=%0d expected=20", money);
    end
  endtask

  task automatic test_simultaneous();
    clear_credit();
    coin(1'b1, 1'b1);
    n_checks++;
    if (money !== 8'd22) begin
      n_fail++;
      $display("FAIL simultaneous_money got=%0d expected=22", money);
    end
  endtask

  task automatic test_saturate();
    clear_credit();
    for (int i = 0; i < 12; i++) coin(1'b0, 1'b1);
    n_checks++;
    if ({sat, money} !== {1'b0, 8'd240}) begin
      n_fail++;
      $display("FAIL sat_before got sat=%0b money=%0d expected sat=0 money=240", sat, money);
    end
    coin(1'b0, 1'b1);
    n_checks++;
    if ({sat, money} !== {1'b1, 8'd255}) begin
      n_fail++;
      $display("FAIL sat_clip got sat=%0b money=%0d expected sat=1 money=255", sat, money);
    end
    coin(1'b1, 1'b0);
    step();
    accurst = 1'b1;
    step();
    accurst = 1'b0;
    m_money = 0;
    m_sat = 1'b0;
    n_checks++;
    if ({sat, money} !== 9'd0) begin
      n_fail++;
      $display("FAIL accurst_clear got sat=%0b money=%0d expected sat=0 money=0", sat, money);
    end
  endtask

  task automatic test_lock();
    int pulses = 0;
    clear_credit();
    coin(1'b1, 1'b0);
    acculock = 1'b1;
    step();
    rmb1_key = 1'b1;
    for (int e = 0; e < 15; e++) begin
      step();
      if (rmb1) pulses++;
    end
    acculock = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (rmb1) pulses++;
    end
    rmb1_key = 1'b0;
    repeat (10) step();
    n_checks++;
    if (pulses != 0 || money !== 8'd2) begin
      n_fail++;
      $display("FAIL lock_hold got pulses=%0d money=%0d expected pulses=0 money=2", pulses, money);
    end
  endtask

  task automatic test_reset_mid();
    int first = 0;
    clear_credit();
    coin(1'b0, 1'b1);
    step();
    rmb1_key = 1'b1;
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rmb10, rmb1, sat, money} !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset got=%h expected=000", {rmb10, rmb1, sat, money});
    end
    m_money = 0;
    m_sat = 1'b0;
    step();
    step();
    model_push(1'b1, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      step();
      if (rmb1 && first == 0) first = e;
    end
    rmb1_key = 1'b0;
    repeat (10) step();
    n_checks++;
    if (first != 6 || money !== 8'd2) begin
      n_fail++;
      $display("FAIL reset_mid_pulse got edge=%0d money=%0d expected edge=6 money=2", first, money);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounce();
    test_simultaneous();
    test_saturate();
    test_lock();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations got=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
